// File: rtl/otter_mmio_router.sv
// Memory-mapped bus router: one master port fanned out to N_SLAVES address regions.
// Three-state handshake (IDLE/ACCESS/RESP) with bus timeout and an error response for unmapped or illegal requests.
module otter_mmio_router #(
  parameter int                      N_SLAVES       = 4,
  parameter logic [32*N_SLAVES-1:0]  SLV_BASE       = {32'h1140_0000, 32'h1120_0000,
                                                       32'h1100_0000, 32'h8000_0000},
  parameter logic [32*N_SLAVES-1:0]  SLV_MASK       = {32'hFFFF_0000, 32'hFFFF_0000,
                                                       32'hFFFF_0000, 32'h8000_0000},
  parameter int                      TIMEOUT_CYCLES = 255,
  parameter logic [31:0]             ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_m_re,
  input  logic                    i_m_we,
  input  logic [3:0]              i_m_sel,
  input  logic [31:0]             i_m_addr,
  input  logic [31:0]             i_m_wdata,
  output logic [31:0]             o_m_rdata,
  output logic                    o_m_ready,
  output logic                    o_m_err,
  output logic [N_SLAVES-1:0]     o_s_re,
  output logic [N_SLAVES-1:0]     o_s_we,
  output logic [4*N_SLAVES-1:0]   o_s_sel,
  output logic [32*N_SLAVES-1:0]  o_s_addr,
  output logic [32*N_SLAVES-1:0]  o_s_wdata,
  input  logic [32*N_SLAVES-1:0]  i_s_rdata,
  input  logic [N_SLAVES-1:0]     i_s_ack
);

  localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Timeout fires on the cycle that would make the count reach TIMEOUT_CYCLES.
  localparam logic [CW-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t          r_state, w_state_next;
  logic [31:0]     r_addr, r_wdata, r_rdata;
  logic [3:0]      r_sel;
  logic            r_re, r_we, r_err;
  logic [SW-1:0]   r_tgt, w_tgt;
  logic [CW-1:0]   r_cnt;

  logic [N_SLAVES-1:0] w_match, w_act;
  logic [31:0]         w_s_rdata [N_SLAVES];
  logic                w_hit, w_req, w_legal, w_ack, w_timeout;

  genvar gi;
  generate
    for (gi = 0; gi < N_SLAVES; gi++) begin : g_slv
      assign w_match[gi]   = (i_m_addr & SLV_MASK[32*gi +: 32]) == SLV_BASE[32*gi +: 32];
      assign w_s_rdata[gi] = i_s_rdata[32*gi +: 32];
      assign w_act[gi]     = (r_state == S_ACCESS) && (r_tgt == SW'(gi));
      assign o_s_re[gi]            = w_act[gi] & r_re;
      assign o_s_we[gi]            = w_act[gi] & r_we;
      assign o_s_sel[4*gi +: 4]    = w_act[gi] ? r_sel   : 4'h0;
      assign o_s_addr[32*gi +: 32] = w_act[gi] ? r_addr  : 32'h0;
      assign o_s_wdata[32*gi +: 32]= w_act[gi] ? r_wdata : 32'h0;
    end
  endgenerate

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    w_tgt = '0;
    w_hit = 1'b0;
    for (int i = N_SLAVES - 1; i >= 0; i--) begin
      if (w_match[i]) begin
        w_tgt = SW'(i);
        w_hit = 1'b1;
      end
    end
  end

  assign w_req     = i_m_re | i_m_we;
  assign w_legal   = w_hit & ~(i_m_re & i_m_we);
  assign w_ack     = i_s_ack[r_tgt];
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (w_req) w_state_next = w_legal ? S_ACCESS : S_RESP;
      S_ACCESS: if (w_ack || w_timeout) w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_sel   <= '0;
      r_re    <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
      r_tgt   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_req) begin
          r_addr  <= i_m_addr;
          r_wdata <= i_m_wdata;
          r_sel   <= i_m_sel;
          r_re    <= i_m_re;
          r_we    <= i_m_we;
          r_tgt   <= w_tgt;
          r_err   <= ~w_legal;
          r_rdata <= '0;
        end
        S_ACCESS: begin
          if (w_ack) begin
            r_rdata <= r_re ? w_s_rdata[r_tgt] : 32'h0;
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_err   <= 1'b1;
          end else if (r_cnt != {CW{1'b1}}) begin
            r_cnt   <= r_cnt + 1'b1;
          end
        end
        S_RESP:  r_cnt <= '0;
        default: r_cnt <= '0;
      endcase
    end
  end

  assign o_m_ready = (r_state == S_RESP);
  assign o_m_err   = o_m_ready & r_err;
  assign o_m_rdata = !o_m_ready ? 32'h0 :
                     r_err      ? (r_re ? ERR_RDATA : 32'h0) : r_rdata;

endmodule
